pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
- Parametrised successor to the RV32I opcode decoder. Decodes the ID-stage instruction into the control bundle and registers it into the ID/EX pipeline register.
- Also owns hazard control:
  - load-use stall and bubble insertion;
  - squash on redirect from EX;
  - optional multi-cycle M-extension occupancy in EX, with a stall counter.
- Sits between the IF/ID register and the EX stage. Drives the stall/flush controls back to fetch.

Parameters:
- REG_AW, 5: register address width.
- ENABLE_M, 1: 1 = decode OP with funct7=0000001 as mul/div; 0 = treat it as illegal.
- MD_LATENCY, 4: number of cycles an M instruction occupies EX; must be ≥1.
- STALL_CW, 16: width of the saturating stall-cycle counter.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- id_valid, in, 1: IF/ID holds a real instruction.
- id_instr, in, 32: instruction in ID; op=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20], funct7=[31:25].
- ex_redirect, in, 1: branch taken or jump resolved in EX this cycle.
- ex_valid, out, 1: ID/EX holds a real instruction.
- ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_branch, ex_jump, ex_jalr, out, 1 each: registered controls.
- ex_mem_to_reg, out, 2: 00 = memory, 01 = ALU, 10 = PC+4.
- ex_alu_op, out, 2: 10 = R-type, 01 = branch, 00 = add.
- ex_md, out, 1: EX instruction is mul/div.
- ex_illegal, out, 1: EX instruction has an unsupported opcode.
- ex_rd, out, REG_AW: destination register.
- ex_op, out, 7: forwarded opcode.
- stall_if_id, out, 1: hold PC and IF/ID this cycle.
- flush_if_id, out, 1: squash IF/ID this cycle.
- ex_hold, out, 1: EX is occupied by mul/div; EX/MEM must latch a bubble.
- stall_cycles, out, STALL_CW: saturating count of cycles with stall_if_id=1.

Behaviour:
- Reset (async, rst_n=0):
  - all ex_* outputs = 0; md counter = 0; stall_cycles = 0.
  - This gives stall_if_id = flush_if_id = ex_hold = 0.
  - Applies mid-operation too: an in-flight mul/div is dropped.
- Decode (combinational, captured into ID/EX):
  - RegWrite for LOAD 0000011, OP 0110011, OP-IMM 0010011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - ALUSrc for LOAD, OP-IMM, STORE 0100011, JALR.
  - MemWrite for STORE only; MemRead for LOAD only.
  - Branch for 1100011; Jump for JAL; Jalr for JALR.
  - MemtoReg: LOAD → 00; JAL/JALR → 10; otherwise 01.
  - ALUOp: OP → 10; BRANCH → 01; otherwise 00.
  - md = ENABLE_M && op==OP && funct7==0000001.
  - Any other opcode, or the M pattern with ENABLE_M=0: all controls 0, illegal=1, valid=1.
- Bubble: ex_valid and every control/illegal/md bit = 0. ex_rd and ex_op = 0.
- Register-use rules:
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by OP, STORE, BRANCH.
  - Register x0 never causes a hazard.
- load_use = ex_valid && ex_mem_read && ex_rd≠0 && id_valid && ((rs1 used && rs1==ex_rd) || (rs2 used && rs2==ex_rd)).
- md_busy = (md counter ≠ 0); ex_hold = md_busy.
- Per-cycle priority (evaluated each cycle, applied at the clock edge):
  1. md_busy: ID/EX holds its value; stall_if_id=1; counter decrements; ex_redirect is ignored.
  2. ex_redirect: flush_if_id=1; stall_if_id=0; ID/EX ← bubble.
  3. load_use: stall_if_id=1; ID/EX ← bubble. This costs exactly one bubble; the dependent instruction enters EX on the next cycle.
  4. Otherwise: ID/EX ← decode(id_instr) if id_valid, else bubble.
- md counter load: when an md instruction is written into ID/EX (case 4), counter ← MD_LATENCY-1.
  - The instruction therefore occupies EX for exactly MD_LATENCY cycles.
  - With MD_LATENCY=1 there is no stall.
- Back-to-back mul/div: the second one sits stalled in ID until the first clears EX, then loads a fresh count.
- stall_cycles: increments on every cycle with stall_if_id=1 and saturates at all-ones.
- Latency: decode → ID/EX is 1 cycle. stall_if_id, flush_if_id and ex_hold are combinational from current state and inputs.

Test Plan:
- Decode sweep: each of the nine opcodes with id_valid=1, one per cycle → the following cycle shows the specified bundle. Examples: JALR gives reg_write=1, alu_src=1, jalr=1, mem_to_reg=10. Opcode 0001111 gives ex_illegal=1 with all other controls 0.
- Load-use: `lw x5` followed by `add x6,x5,x1` → stall_if_id=1 for one cycle and one bubble in EX; the add appears next. With `lw x0` followed by `add x6,x0,x1` → no stall.
- Redirect: ex_redirect=1 while a load-use condition is present → flush_if_id=1, stall_if_id=0, ID/EX gets a bubble.
- Mul/div with MD_LATENCY=4: `mul` enters EX → ex_hold=1 and stall_if_id=1 for 3 cycles, ID/EX unchanged, an ex_redirect pulse during this window is ignored; the next instruction enters EX on cycle 5. Repeat with ENABLE_M=0 → ex_illegal=1 and no hold.
- Reset mid-mul: rst_n driven low in the 2nd busy cycle → ex_hold=0 and all outputs 0 immediately; after release, normal decode resumes.
- Saturation with STALL_CW=4: drive 20 load-use stalls → stall_cycles stops at 15.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control: decodes the RV32I instruction into the ID/EX control register and
// resolves load-use stalls, redirect squashes and multi-cycle mul/div occupancy of EX.
module pipe_ctrl_unit #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned ENABLE_M   = 1,
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned STALL_CW   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [31:0]         id_instr,
    input  logic                ex_redirect,
    output logic                ex_valid,
    output logic                ex_reg_write,
    output logic                ex_alu_src,
    output logic                ex_mem_write,
    output logic                ex_mem_read,
    output logic                ex_branch,
    output logic                ex_jump,
    output logic                ex_jalr,
    output logic [1:0]          ex_mem_to_reg,
    output logic [1:0]          ex_alu_op,
    output logic                ex_md,
    output logic                ex_illegal,
    output logic [REG_AW-1:0]   ex_rd,
    output logic [6:0]          ex_op,
    output logic                stall_if_id,
    output logic                flush_if_id,
    output logic                ex_hold,
    output logic [STALL_CW-1:0] stall_cycles
);

    localparam int unsigned MD_CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [MD_CW-1:0] MD_LOAD = MD_CW'(MD_LATENCY - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_MD     = 7'b0000001;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              alu_src;
        logic              mem_write;
        logic              mem_read;
        logic              branch;
        logic              jump;
        logic              jalr;
        logic [1:0]        mem_to_reg;
        logic [1:0]        alu_op;
        logic              md;
        logic              illegal;
        logic [REG_AW-1:0] rd;
        logic [6:0]        op;
    } id_ex_t;

    id_ex_t              ex_q, ex_d, dec;
    logic [MD_CW-1:0]    md_cnt_q, md_cnt_d;
    logic [STALL_CW-1:0] stall_cnt_q, stall_cnt_d;

    logic [6:0]        op;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rs1, rs2;
    logic              rs1_used, rs2_used;
    logic              load_use, md_busy;
    logic              stall_c, flush_c;
    logic              unused_funct3;

    assign op            = id_instr[6:0];
    assign funct7        = id_instr[31:25];
    assign rs1           = REG_AW'(id_instr[19:15]);
    assign rs2           = REG_AW'(id_instr[24:20]);
    assign unused_funct3 = ^id_instr[14:12];

    // Instruction decode into the ID/EX bundle.
    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.rd    = REG_AW'(id_instr[11:7]);
        dec.op    = op;
        case (op)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 2'b00;
            end
            OP_OP: begin
                if ((funct7 == F7_MD) && (ENABLE_M == 0)) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.reg_write  = 1'b1;
                    dec.mem_to_reg = 2'b01;
                    dec.alu_op     = 2'b10;
                    dec.md         = (funct7 == F7_MD);
                end
            end
            OP_IMM: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 2'b01;
            end
            OP_STORE: begin
                dec.alu_src    = 1'b1;
                dec.mem_write  = 1'b1;
                dec.mem_to_reg = 2'b01;
            end
            OP_BRANCH: begin
                dec.branch     = 1'b1;
                dec.mem_to_reg = 2'b01;
                dec.alu_op     = 2'b01;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.mem_to_reg = 2'b10;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.jalr       = 1'b1;
                dec.mem_to_reg = 2'b10;
            end
            OP_LUI, OP_AUIPC: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 2'b01;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Source-register usage for hazard detection.
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (op)
            OP_OP, OP_STORE, OP_BRANCH: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: rs1_used = 1'b1;
            default: ;
        endcase
    end

    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                      ((rs1_used && (rs1 == ex_q.rd)) || (rs2_used && (rs2 == ex_q.rd)));
    assign md_busy  = (md_cnt_q != '0);

    // Hazard priority: mul/div occupancy, then redirect, then load-use, then normal issue.
    always_comb begin
        ex_d        = ex_q;
        md_cnt_d    = md_cnt_q;
        stall_c     = 1'b0;
        flush_c     = 1'b0;
        if (md_busy) begin
            stall_c  = 1'b1;
            md_cnt_d = md_cnt_q - MD_CW'(1);
        end else if (ex_redirect) begin
            flush_c = 1'b1;
            ex_d    = '0;
        end else if (load_use) begin
            stall_c = 1'b1;
            ex_d    = '0;
        end else begin
            ex_d = id_valid ? dec : '0;
            if (id_valid && dec.md) begin
                md_cnt_d = MD_LOAD;
            end
        end
        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_branch     = ex_q.branch;
    assign ex_jump       = ex_q.jump;
    assign ex_jalr       = ex_q.jalr;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_md         = ex_q.md;
    assign ex_illegal    = ex_q.illegal;
    assign ex_rd         = ex_q.rd;
    assign ex_op         = ex_q.op;
    assign stall_if_id   = stall_c;
    assign flush_if_id   = flush_c;
    assign ex_hold       = md_busy;
    assign stall_cycles  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode table plus load-use, redirect, mul/div,
// mid-operation reset and stall-counter saturation sequences.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_OP = 7'b0110011, OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    // Expected bundle order: {valid,rw,alu_src,mem_wr,mem_rd,branch,jump,jalr,m2r[1:0],alu_op[1:0],md,illegal}
    localparam logic [13:0] B_LOAD = 14'b1110_1000_0000_00;
    localparam logic [13:0] B_OP   = 14'b1100_0000_0110_00;
    localparam logic [13:0] B_IMM  = 14'b1110_0000_0100_00;
    localparam logic [13:0] B_ST   = 14'b1011_0000_0100_00;
    localparam logic [13:0] B_BR   = 14'b1000_0100_0101_00;
    localparam logic [13:0] B_JAL  = 14'b1100_0010_1000_00;
    localparam logic [13:0] B_JALR = 14'b1110_0001_1000_00;
    localparam logic [13:0] B_U    = 14'b1100_0000_0100_00;
    localparam logic [13:0] B_ILL  = 14'b1000_0000_0000_01;
    localparam logic [13:0] B_MUL  = 14'b1100_0000_0110_10;
    localparam logic [13:0] B_NONE = 14'b0;

    logic clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, ex_redirect = 1'b0;
    logic [31:0] id_instr = '0;

    logic ex_valid, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_branch;
    logic ex_jump, ex_jalr, ex_md, ex_illegal, stall_if_id, flush_if_id, ex_hold;
    logic [1:0] ex_mem_to_reg, ex_alu_op;
    logic [4:0] ex_rd;
    logic [6:0] ex_op;
    logic [3:0] stall_cycles;

    logic n_valid, n_rw, n_as, n_mw, n_mr, n_br, n_j, n_jr, n_md, n_ill, n_stall, n_flush, n_hold;
    logic [1:0] n_m2r, n_aop;
    logic [4:0] n_rd;
    logic [6:0] n_op;
    logic [3:0] n_sc;

    logic l_valid, l_rw, l_as, l_mw, l_mr, l_br, l_j, l_jr, l_md, l_ill, l_stall, l_flush, l_hold;
    logic [1:0] l_m2r, l_aop;
    logic [4:0] l_rd;
    logic [6:0] l_op;
    logic [15:0] l_sc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_AW(5), .ENABLE_M(1), .MD_LATENCY(4), .STALL_CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .ex_redirect(ex_redirect), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_alu_src(ex_alu_src), .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op), .ex_md(ex_md),
        .ex_illegal(ex_illegal), .ex_rd(ex_rd), .ex_op(ex_op), .stall_if_id(stall_if_id),
        .flush_if_id(flush_if_id), .ex_hold(ex_hold), .stall_cycles(stall_cycles)
    );

    pipe_ctrl_unit #(.REG_AW(5), .ENABLE_M(0), .MD_LATENCY(4), .STALL_CW(4)) dut_nm (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .ex_redirect(ex_redirect), .ex_valid(n_valid), .ex_reg_write(n_rw),
        .ex_alu_src(n_as), .ex_mem_write(n_mw), .ex_mem_read(n_mr),
        .ex_branch(n_br), .ex_jump(n_j), .ex_jalr(n_jr),
        .ex_mem_to_reg(n_m2r), .ex_alu_op(n_aop), .ex_md(n_md),
        .ex_illegal(n_ill), .ex_rd(n_rd), .ex_op(n_op), .stall_if_id(n_stall),
        .flush_if_id(n_flush), .ex_hold(n_hold), .stall_cycles(n_sc)
    );

    pipe_ctrl_unit #(.REG_AW(5), .ENABLE_M(1), .MD_LATENCY(1), .STALL_CW(16)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .ex_redirect(ex_redirect), .ex_valid(l_valid), .ex_reg_write(l_rw),
        .ex_alu_src(l_as), .ex_mem_write(l_mw), .ex_mem_read(l_mr),
        .ex_branch(l_br), .ex_jump(l_j), .ex_jalr(l_jr),
        .ex_mem_to_reg(l_m2r), .ex_alu_op(l_aop), .ex_md(l_md),
        .ex_illegal(l_ill), .ex_rd(l_rd), .ex_op(l_op), .stall_if_id(l_stall),
        .flush_if_id(l_flush), .ex_hold(l_hold), .stall_cycles(l_sc)
    );

    typedef struct {
        logic        vld;
        logic [31:0] instr;
        logic        redir;
        logic        stall;
        logic        flush;
        logic [13:0] bun;
        logic [4:0]  rd;
        logic [6:0]  op;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [4:0] rd,
                                       input logic [6:0] op);
        return {f7, rs2, rs1, 3'b000, rd, op};
    endfunction

    function automatic logic [13:0] bun_main();
        return {ex_valid, ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_branch,
                ex_jump, ex_jalr, ex_mem_to_reg, ex_alu_op, ex_md, ex_illegal};
    endfunction

    function automatic logic [13:0] bun_nm();
        return {n_valid, n_rw, n_as, n_mw, n_mr, n_br, n_j, n_jr, n_m2r, n_aop, n_md, n_ill};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] instr, input logic redir);
        id_valid    = vld;
        id_instr    = instr;
        ex_redirect = redir;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, mk(7'h00, 5'd0, 5'd1, 5'd5, OP_LOAD), 1'b0, 1'b0, 1'b0, B_LOAD, 5'd5, OP_LOAD};
        vecs[1]  = '{1'b1, mk(7'h00, 5'd3, 5'd2, 5'd6, OP_OP), 1'b0, 1'b0, 1'b0, B_OP, 5'd6, OP_OP};
        vecs[2]  = '{1'b1, mk(7'h20, 5'd3, 5'd2, 5'd6, OP_OP), 1'b0, 1'b0, 1'b0, B_OP, 5'd6, OP_OP};
        vecs[3]  = '{1'b1, mk(7'h00, 5'd0, 5'd1, 5'd7, OP_IMM), 1'b0, 1'b0, 1'b0, B_IMM, 5'd7, OP_IMM};
        vecs[4]  = '{1'b1, mk(7'h00, 5'd3, 5'd2, 5'd4, OP_ST), 1'b0, 1'b0, 1'b0, B_ST, 5'd4, OP_ST};
        vecs[5]  = '{1'b1, mk(7'h00, 5'd2, 5'd1, 5'd8, OP_BR), 1'b0, 1'b0, 1'b0, B_BR, 5'd8, OP_BR};
        vecs[6]  = '{1'b1, mk(7'h00, 5'd0, 5'd0, 5'd1, OP_JAL), 1'b0, 1'b0, 1'b0, B_JAL, 5'd1, OP_JAL};
        vecs[7]  = '{1'b1, mk(7'h00, 5'd0, 5'd1, 5'd9, OP_JALR), 1'b0, 1'b0, 1'b0, B_JALR, 5'd9, OP_JALR};
        vecs[8]  = '{1'b1, mk(7'h00, 5'd0, 5'd0, 5'd10, OP_LUI), 1'b0, 1'b0, 1'b0, B_U, 5'd10, OP_LUI};
        vecs[9]  = '{1'b1, mk(7'h00, 5'd0, 5'd0, 5'd11, OP_AUIPC), 1'b0, 1'b0, 1'b0, B_U, 5'd11, OP_AUIPC};
        vecs[10] = '{1'b1, mk(7'h00, 5'd0, 5'd0, 5'd12, OP_FENCE), 1'b0, 1'b0, 1'b0, B_ILL, 5'd12, OP_FENCE};
        vecs[11] = '{1'b0, mk(7'h00, 5'd0, 5'd0, 5'd3, OP_LUI), 1'b0, 1'b0, 1'b0, B_NONE, 5'd0, 7'd0};
        vecs[12] = '{1'b1, mk(7'h00, 5'd0, 5'd0, 5'd13, OP_LUI), 1'b1, 1'b0, 1'b1, B_NONE, 5'd0, 7'd0};
        vecs[13] = '{1'b1, mk(7'h00, 5'd0, 5'd1, 5'd0, OP_LOAD), 1'b0, 1'b0, 1'b0, B_LOAD, 5'd0, OP_LOAD};

        // Reset state
        cyc();
        cyc();
        chk("reset_bundle", 32'(bun_main()), 32'(B_NONE));
        chk("reset_rd_op", 32'({ex_rd, ex_op}), 32'd0);
        chk("reset_ctrl", 32'({stall_if_id, flush_if_id, ex_hold}), 32'd0);
        chk("reset_stall_cycles", 32'(stall_cycles), 32'd0);
        rst_n = 1'b1;

        // Decode table
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].vld, vecs[i].instr, vecs[i].redir);
            chk($sformatf("vec%0d_stall", i), 32'(stall_if_id), 32'(vecs[i].stall));
            chk($sformatf("vec%0d_flush", i), 32'(flush_if_id), 32'(vecs[i].flush));
            cyc();
            chk($sformatf("vec%0d_bundle", i), 32'(bun_main()), 32'(vecs[i].bun));
            chk($sformatf("vec%0d_rd", i), 32'(ex_rd), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_op", i), 32'(ex_op), 32'(vecs[i].op));
        end

        // lw x0 then add x6,x0,x1: no hazard on x0
        drive(1'b1, mk(7'h00, 5'd1, 5'd0, 5'd6, OP_OP), 1'b0);
        chk("x0_no_stall", 32'(stall_if_id), 32'd0);
        cyc();
        chk("x0_add_bundle", 32'({bun_main(), ex_rd}), 32'({B_OP, 5'd6}));

        // lw x5 then add x6,x5,x1: one stall, one bubble
        drive(1'b1, mk(7'h00, 5'd0, 5'd1, 5'd5, OP_LOAD), 1'b0);
        chk("lu_lw_no_stall", 32'(stall_if_id), 32'd0);
        cyc();
        drive(1'b1, mk(7'h00, 5'd1, 5'd5, 5'd6, OP_OP), 1'b0);
        chk("lu_stall", 32'(stall_if_id), 32'd1);
        chk("lu_no_flush", 32'(flush_if_id), 32'd0);
        cyc();
        chk("lu_bubble", 32'({bun_main(), ex_rd, ex_op}), 32'd0);
        chk("lu_stall_released", 32'(stall_if_id), 32'd0);
        cyc();
        chk("lu_add_enters", 32'({bun_main(), ex_rd}), 32'({B_OP, 5'd6}));
        chk("lu_stall_cycles", 32'(stall_cycles), 32'd1);

        // Redirect beats load-use
        drive(1'b1, mk(7'h00, 5'd0, 5'd1, 5'd5, OP_LOAD), 1'b0);
        cyc();
        drive(1'b1, mk(7'h00, 5'd1, 5'd5, 5'd6, OP_OP), 1'b1);
        chk("redir_flush", 32'(flush_if_id), 32'd1);
        chk("redir_no_stall", 32'(stall_if_id), 32'd0);
        cyc();
        chk("redir_bubble", 32'(bun_main()), 32'(B_NONE));
        chk("redir_stall_cycles", 32'(stall_cycles), 32'd1);

        // mul with MD_LATENCY=4; redirect during busy ignored
        drive(1'b1, mk(7'h01, 5'd3, 5'd2, 5'd7, OP_OP), 1'b0);
        cyc();
        chk("mul_enter", 32'({bun_main(), ex_rd}), 32'({B_MUL, 5'd7}));
        chk("nm_mul_illegal", 32'(bun_nm()), 32'(B_ILL));
        chk("nm_no_hold", 32'({n_hold, n_stall}), 32'd0);
        chk("l1_md_no_hold", 32'({l_md, l_hold, l_stall}), 32'b100);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, mk(7'h00, 5'd0, 5'd1, 5'd8, OP_IMM), (k == 2));
            chk($sformatf("mul_hold%0d", k), 32'({ex_hold, stall_if_id, flush_if_id}), 32'b110);
            chk($sformatf("mul_held%0d", k), 32'({bun_main(), ex_rd}), 32'({B_MUL, 5'd7}));
            cyc();
        end
        drive(1'b1, mk(7'h00, 5'd0, 5'd1, 5'd8, OP_IMM), 1'b0);
        chk("mul_cycle4_free", 32'({ex_hold, stall_if_id}), 32'd0);
        chk("mul_cycle4_still", 32'(ex_md), 32'd1);
        cyc();
        chk("mul_next_enters", 32'({bun_main(), ex_rd}), 32'({B_IMM, 5'd8}));
        chk("mul_stall_cycles", 32'(stall_cycles), 32'd4);

        // Back-to-back mul/div
        drive(1'b1, mk(7'h01, 5'd3, 5'd2, 5'd7, OP_OP), 1'b0);
        cyc();
        drive(1'b1, mk(7'h01, 5'd3, 5'd2, 5'd9, OP_OP), 1'b0);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("b2b_stall%0d", k), 32'({stall_if_id, ex_rd}), 32'({1'b1, 5'd7}));
            cyc();
        end
        chk("b2b_cycle4_free", 32'(ex_hold), 32'd0);
        cyc();
        chk("b2b_second", 32'({bun_main(), ex_rd, ex_hold}), 32'({B_MUL, 5'd9, 1'b1}));
        drive(1'b0, 32'd0, 1'b0);
        cyc();
        cyc();
        cyc();
        chk("b2b_stall_cycles", 32'(stall_cycles), 32'd10);

        // Reset during the second busy cycle of a mul
        drive(1'b1, mk(7'h01, 5'd3, 5'd2, 5'd7, OP_OP), 1'b0);
        cyc();
        cyc();
        chk("rst_pre_hold", 32'(ex_hold), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_hold", 32'({ex_hold, stall_if_id, flush_if_id}), 32'd0);
        chk("rst_mid_bundle", 32'({bun_main(), ex_rd, ex_op}), 32'd0);
        chk("rst_mid_stall_cycles", 32'(stall_cycles), 32'd0);
        cyc();
        rst_n = 1'b1;
        drive(1'b1, mk(7'h00, 5'd0, 5'd1, 5'd8, OP_IMM), 1'b0);
        cyc();
        chk("rst_resume", 32'({bun_main(), ex_rd, ex_hold}), 32'({B_IMM, 5'd8, 1'b0}));

        // 20 load-use stalls saturate a 4-bit counter at 15
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, mk(7'h00, 5'd0, 5'd1, 5'd5, OP_LOAD), 1'b0);
            cyc();
            drive(1'b1, mk(7'h00, 5'd1, 5'd5, 5'd6, OP_OP), 1'b0);
            cyc();
            chk($sformatf("sat%0d", i), 32'(stall_cycles), (i + 1 < 15) ? 32'(i + 1) : 32'd15);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
